// File: rtl/peripheral_adder_pkg.sv
// Shared widths and stage payload types for the two-stage pipelined adder responder.
package peripheral_adder_pkg;

   localparam int unsigned ADD_W   = 4;
   localparam int unsigned ADD_LO  = ADD_W / 2;
   localparam int unsigned ADD_LO1 = ADD_LO + 1;

   // Low half already summed; high operand halves wait for stage 2.
   typedef struct packed {
      logic [ADD_LO-1:0] lo_sum;
      logic              c_lo;
      logic [ADD_LO-1:0] x_hi;
      logic [ADD_LO-1:0] y_hi;
   } s1_payload_t;

   typedef struct packed {
      logic [ADD_W-1:0] sum;
      logic             cout;
      logic             ovf;
   } result_t;

endpackage

// File: rtl/peripheral_adder_pipe_reg.sv
// Generic valid/ready register slice: loads valid on enable, payload only when valid.
module peripheral_adder_pipe_reg #(
   parameter type T = logic
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic in_valid,
   input  T     in_data,
   output logic out_valid,
   output T     out_data
);

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (en) begin
         out_valid <= in_valid;
         if (in_valid) out_data <= in_data;
      end
   end

endmodule

// File: rtl/peripheral_adder_responder.sv
// Responder: accepts (x, y, cin), returns registered sum/cout/ovf through a 2-stage ripple adder.
module peripheral_adder_responder
   import peripheral_adder_pkg::*;
#(
   parameter int unsigned W     = ADD_W,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     x,
   input  logic [W-1:0]     y,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     sum,
   output logic             cout,
   output logic             ovf,
   output logic [CNT_W-1:0] txn_count
);

   logic          s1_valid;
   logic          en1;
   logic          en2;
   logic [ADD_LO:0] lo_full;
   logic [ADD_LO:0] hi_full;
   s1_payload_t   s1_d;
   s1_payload_t   s1_q;
   result_t       res_d;
   result_t       res_q;

   // Stage 2 advances when empty or drained; stage 1 advances when empty or stage 2 moves.
   assign en2      = !out_valid || out_ready;
   assign en1      = !s1_valid || en2;
   assign in_ready = en1;

   always_comb begin
      s1_d        = '0;
      lo_full     = ADD_LO1'(x[ADD_LO-1:0]) + ADD_LO1'(y[ADD_LO-1:0]) + ADD_LO1'(cin);
      s1_d.lo_sum = lo_full[ADD_LO-1:0];
      s1_d.c_lo   = lo_full[ADD_LO];
      s1_d.x_hi   = x[W-1:ADD_LO];
      s1_d.y_hi   = y[W-1:ADD_LO];
   end

   // Carry into the MSB is recovered as a ^ b ^ s of that bit.
   always_comb begin
      res_d      = '0;
      hi_full    = ADD_LO1'(s1_q.x_hi) + ADD_LO1'(s1_q.y_hi) + ADD_LO1'(s1_q.c_lo);
      res_d.sum  = {hi_full[ADD_LO-1:0], s1_q.lo_sum};
      res_d.cout = hi_full[ADD_LO];
      res_d.ovf  = s1_q.x_hi[ADD_LO-1] ^ s1_q.y_hi[ADD_LO-1] ^ hi_full[ADD_LO-1] ^ hi_full[ADD_LO];
   end

   peripheral_adder_pipe_reg #(.T(s1_payload_t)) u_stage1 (
      .clk       (clk),
      .reset     (reset),
      .en        (en1),
      .in_valid  (in_valid),
      .in_data   (s1_d),
      .out_valid (s1_valid),
      .out_data  (s1_q)
   );

   peripheral_adder_pipe_reg #(.T(result_t)) u_stage2 (
      .clk       (clk),
      .reset     (reset),
      .en        (en2),
      .in_valid  (s1_valid),
      .in_data   (res_d),
      .out_valid (out_valid),
      .out_data  (res_q)
   );

   assign sum  = res_q.sum;
   assign cout = res_q.cout;
   assign ovf  = res_q.ovf;

   always_ff @(posedge clk) begin
      if (reset) txn_count <= '0;
      else if (out_valid && out_ready) txn_count <= txn_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_peripheral_adder_responder.sv
// Self-checking bench for peripheral_adder_responder (W=4, CNT_W=4).
module tb_peripheral_adder_responder;

   localparam int unsigned W     = 4;
   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     x;
   logic [W-1:0]     y;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     sum;
   logic             cout;
   logic             ovf;
   logic [CNT_W-1:0] txn_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int x;
      int y;
      int cin;
      int e_sum;
      int e_cout;
      int e_ovf;
   } vec_t;

   typedef struct {
      int s;
      int c;
      int o;
   } res_t;

   peripheral_adder_responder #(.W(W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .txn_count (txn_count)
   );

   always #5 clk = ~clk;

   // Reference: unsigned total for sum/cout, signed total for overflow.
   function automatic res_t model(int a, int b, int c);
      res_t r;
      int   t, sa, sb, st;
      t   = a + b + c;
      r.s = t % 16;
      r.c = t / 16;
      sa  = (a >= 8) ? a - 16 : a;
      sb  = (b >= 8) ? b - 16 : b;
      st  = sa + sb + c;
      r.o = (st > 7 || st < -8) ? 1 : 0;
      return r;
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic v, int a, int b, int c);
      in_valid = v;
      x        = W'(a);
      y        = W'(b);
      cin      = c[0];
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 0, 0, 0);
      tick();
      reset = 1'b0;
   endtask

   task automatic check_out(string name, int s, int c, int o);
      check({name, "_valid"}, int'(out_valid), 1);
      check({name, "_sum"},   int'(sum),  s);
      check({name, "_cout"},  int'(cout), c);
      check({name, "_ovf"},   int'(ovf),  o);
   endtask

   // Continuous streaming of n random transactions; results and count checked every cycle.
   task automatic stream(int n);
      res_t exp_q[$];
      res_t r;
      int   a, b, c, consumed;
      out_ready = 1'b1;
      for (int j = 0; j <= n + 1; j++) begin
         if (j < n) begin
            a = int'($urandom_range(15));
            b = int'($urandom_range(15));
            c = int'($urandom_range(1));
            drive(1'b1, a, b, c);
            exp_q.push_back(model(a, b, c));
            #0;
            check("stream_in_ready", int'(in_ready), 1);
         end else begin
            drive(1'b0, 0, 0, 0);
         end
         tick();
         consumed = (j - 1 < 0) ? 0 : ((j - 1 > n) ? n : j - 1);
         check("stream_count", int'(txn_count), consumed % 16);
         if (j >= 1 && j <= n) begin
            r = exp_q.pop_front();
            check_out("stream", r.s, r.c, r.o);
         end else if (j == n + 1) begin
            check("stream_drained", int'(out_valid), 0);
         end
      end
   endtask

   initial begin
      vec_t vecs[6];
      vecs[0] = '{7,  8,  1, 0,  1, 0};
      vecs[1] = '{7,  1,  0, 8,  0, 1};
      vecs[2] = '{8,  8,  0, 0,  1, 1};
      vecs[3] = '{3,  4,  0, 7,  0, 0};
      vecs[4] = '{15, 15, 1, 15, 1, 0};
      vecs[5] = '{5,  10, 1, 0,  1, 0};

      out_ready = 1'b1;
      reset     = 1'b1;
      drive(1'b0, 0, 0, 0);
      tick();
      tick();
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_sum",       int'(sum), 0);
      check("rst_cout",      int'(cout), 0);
      check("rst_ovf",       int'(ovf), 0);
      check("rst_count",     int'(txn_count), 0);
      reset = 1'b0;
      tick();
      check("rst_in_ready",  int'(in_ready), 1);

      // Single transactions: accepted at edge k, visible after edge k+1.
      foreach (vecs[i]) begin
         drive(1'b1, vecs[i].x, vecs[i].y, vecs[i].cin);
         tick();
         drive(1'b0, 0, 0, 0);
         tick();
         check_out($sformatf("vec%0d", i), vecs[i].e_sum, vecs[i].e_cout, vecs[i].e_ovf);
      end
      tick();
      check("vec_count", int'(txn_count), 6);
      check("vec_idle",  int'(out_valid), 0);

      do_reset();
      stream(10);
      check("stream10_count", int'(txn_count), 10);

      // Backpressure: A held, B parked in stage 1, C stalled until out_ready rises.
      do_reset();
      out_ready = 1'b0;
      drive(1'b1, 3, 4, 0);
      #0;
      check("bp_ready_a", int'(in_ready), 1);
      tick();
      drive(1'b1, 5, 5, 1);
      #0;
      check("bp_ready_b", int'(in_ready), 1);
      tick();
      drive(1'b1, 1, 1, 0);
      #0;
      check("bp_ready_c", int'(in_ready), 0);
      check_out("bp_hold0", 7, 0, 0);
      tick();
      tick();
      check_out("bp_hold1", 7, 0, 0);
      check("bp_ready_c2", int'(in_ready), 0);
      tick();
      check_out("bp_hold2", 7, 0, 0);
      out_ready = 1'b1;
      #0;
      check("bp_ready_rel", int'(in_ready), 1);
      tick();
      drive(1'b0, 0, 0, 0);
      check_out("bp_b", 11, 0, 1);
      tick();
      check_out("bp_c", 2, 0, 0);
      tick();
      check("bp_empty", int'(out_valid), 0);
      check("bp_count", int'(txn_count), 3);

      // Reset with two transactions in flight discards both.
      out_ready = 1'b0;
      drive(1'b1, 6, 6, 0);
      tick();
      drive(1'b1, 9, 2, 1);
      tick();
      drive(1'b0, 0, 0, 0);
      check("mid_full", int'(out_valid), 1);
      do_reset();
      #0;
      check("mid_out_valid", int'(out_valid), 0);
      check("mid_count",     int'(txn_count), 0);
      check("mid_sum",       int'(sum), 0);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("mid_no_ghost", int'(out_valid), 0);
      end
      drive(1'b1, 2, 3, 0);
      tick();
      drive(1'b0, 0, 0, 0);
      tick();
      check_out("mid_next", 5, 0, 0);
      tick();
      check("mid_next_count", int'(txn_count), 1);

      // Counter wrap: 17 consumed results walk 15 -> 0 -> 1.
      do_reset();
      stream(17);
      check("wrap_count", int'(txn_count), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
